// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt core.
package pic_pkg;
  localparam int NUM_IR = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } pic_state_e;

  // OCW2 bits [7:5] = {R, SL, EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority scan starting at the rotation base (base = highest priority).
// A request only wins if it is strictly above the highest in-service level.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] isr,
  input  logic [2:0]        base,
  output logic [2:0]        req_lvl,
  output logic              req_vld,
  output logic [2:0]        isr_lvl,
  output logic              isr_vld
);
  logic [2:0] idx;
  logic       blocked;

  always_comb begin
    req_lvl = '0;
    req_vld = 1'b0;
    isr_lvl = '0;
    isr_vld = 1'b0;
    blocked = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      idx = base + 3'(i);
      // an in-service level blocks itself and everything below it
      if (isr[idx]) begin
        if (!isr_vld) begin
          isr_vld = 1'b1;
          isr_lvl = idx;
        end
        blocked = 1'b1;
      end
      if (req[idx] && !blocked && !req_vld) begin
        req_vld = 1'b1;
        req_lvl = idx;
      end
    end
  end
endmodule

// File: rtl/pic_control_logic.sv
// 8259A-style interrupt core: IRR/IMR/ISR, fully nested priority, 8086 two-pulse INTA.
// Define PIC_ROTATE_PRIORITY_EN to enable OCW2 priority rotation commands.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icw_done,
  input  logic              icw1_ltim,
  input  logic [4:0]        icw2_base,
  input  logic              icw4_aeoi,
  input  logic [NUM_IR-1:0] ocw1_mask,
  input  logic [7:0]        ocw2,
  input  logic              ocw2_wr,
  input  logic              rd_ris,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  output logic              int_out,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [7:0]        status_out
);
  logic [SYNC_STAGES-1:0][NUM_IR-1:0] ir_sync;
  logic [SYNC_STAGES-1:0]             inta_sync;
  logic [NUM_IR-1:0] ir_s, ir_prev, irr, isr, irr_nxt, isr_nxt, req, eoi_clr;
  logic              inta_s, inta_prev, inta_fall, inta_rise, ack1, aeoi_clr_en;
  logic [2:0]        lvl, rot_base, req_lvl, isr_lvl;
  logic              req_vld, isr_vld;
  logic              unused_ocw2;
  pic_state_e        state;

  assign ir_s        = ir_sync[SYNC_STAGES-1];
  assign inta_s      = inta_sync[SYNC_STAGES-1];
  assign inta_fall   = inta_prev & ~inta_s;
  assign inta_rise   = ~inta_prev & inta_s;
  assign ack1        = (state == IDLE) && inta_fall;
  assign aeoi_clr_en = (state == ACK2) && inta_rise && icw4_aeoi;
  assign unused_ocw2 = ^ocw2[4:3];

  // An edge request whose line has already dropped cannot win the first INTA.
  assign req = irr & ~ocw1_mask & ((ack1 && !icw1_ltim) ? ir_s : '1);

  pic_priority_resolver u_res (
    .req     (req),
    .isr     (isr),
    .base    (rot_base),
    .req_lvl (req_lvl),
    .req_vld (req_vld),
    .isr_lvl (isr_lvl),
    .isr_vld (isr_vld)
  );

`ifdef PIC_ROTATE_PRIORITY_EN
  logic       rot_upd, rot_aeoi;
  logic [2:0] rot_new;
`endif

  always_comb begin
    eoi_clr = '0;
`ifdef PIC_ROTATE_PRIORITY_EN
    rot_upd = 1'b0;
    rot_new = rot_base;
`endif
    if (ocw2_wr) begin
      case (ocw2[7:5])
`ifdef PIC_ROTATE_PRIORITY_EN
        OCW2_NS_EOI: if (isr_vld) eoi_clr[isr_lvl] = 1'b1;
        OCW2_SP_EOI: eoi_clr[ocw2[2:0]] = 1'b1;
        OCW2_ROT_NS_EOI: if (isr_vld) begin
          eoi_clr[isr_lvl] = 1'b1;
          rot_upd = 1'b1;
          rot_new = isr_lvl + 3'd1;
        end
        OCW2_ROT_SP_EOI: begin
          eoi_clr[ocw2[2:0]] = 1'b1;
          rot_upd = 1'b1;
          rot_new = ocw2[2:0] + 3'd1;
        end
        OCW2_SET_PRI: begin
          rot_upd = 1'b1;
          rot_new = ocw2[2:0] + 3'd1;
        end
        OCW2_NOP, OCW2_ROT_AEOI_SET, OCW2_ROT_AEOI_CLR: ;
`else
        OCW2_NS_EOI, OCW2_ROT_NS_EOI: if (isr_vld) eoi_clr[isr_lvl] = 1'b1;
        OCW2_SP_EOI, OCW2_ROT_SP_EOI: eoi_clr[ocw2[2:0]] = 1'b1;
        OCW2_NOP, OCW2_SET_PRI, OCW2_ROT_AEOI_SET, OCW2_ROT_AEOI_CLR: ;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    irr_nxt = icw1_ltim ? ir_s : (irr | (ir_s & ~ir_prev));
    if (ack1) begin
      irr_nxt = irr_nxt & ir_s;
      if (req_vld) irr_nxt[req_lvl] = 1'b0;
    end
    isr_nxt = isr & ~eoi_clr;
    if (aeoi_clr_en) isr_nxt[lvl] = 1'b0;
    // set wins over a same-cycle EOI on the same bit
    if (ack1 && req_vld) isr_nxt[req_lvl] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sync    <= '0;
      inta_sync  <= '0;
      ir_prev    <= '0;
      inta_prev  <= 1'b0;
      irr        <= '0;
      isr        <= '0;
      state      <= IDLE;
      lvl        <= '0;
      int_out    <= 1'b0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      status_out <= '0;
    end else begin
      ir_sync   <= {ir_sync[SYNC_STAGES-2:0], ir};
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      ir_prev   <= ir_s;
      inta_prev <= inta_s;
      if (!icw_done) begin
        irr        <= '0;
        isr        <= '0;
        state      <= IDLE;
        lvl        <= '0;
        int_out    <= 1'b0;
        data_out   <= '0;
        data_oe    <= 1'b0;
        status_out <= '0;
      end else begin
        irr        <= irr_nxt;
        isr        <= isr_nxt;
        status_out <= rd_ris ? isr : irr;
        int_out    <= 1'b0;
        case (state)
          IDLE: begin
            if (inta_fall) begin
              state <= ACK1;
              lvl   <= req_vld ? req_lvl : 3'(SPURIOUS_LEVEL);
            end else begin
              int_out <= req_vld;
            end
          end
          ACK1: if (inta_fall) begin
            state    <= ACK2;
            data_out <= {icw2_base, lvl};
            data_oe  <= 1'b1;
          end
          ACK2: if (inta_rise) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PIC_ROTATE_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_base <= '0;
      rot_aeoi <= 1'b0;
    end else if (!icw_done) begin
      rot_base <= '0;
      rot_aeoi <= 1'b0;
    end else begin
      if (rot_upd) rot_base <= rot_new;
      if (aeoi_clr_en && rot_aeoi) rot_base <= lvl + 3'd1;
      if (ocw2_wr && ocw2[7:5] == OCW2_ROT_AEOI_SET) rot_aeoi <= 1'b1;
      if (ocw2_wr && ocw2[7:5] == OCW2_ROT_AEOI_CLR) rot_aeoi <= 1'b0;
    end
  end
`else
  assign rot_base = '0;
`endif
endmodule

// File: tb/tb_pic_control_logic.sv
// Scoreboard bench: vectors queued at stimulus time, popped by a data_oe monitor.
module tb_pic_control_logic;
  logic       clk = 1'b0, rst_n = 1'b0, icw_done = 1'b0, icw1_ltim = 1'b0;
  logic       icw4_aeoi = 1'b0, ocw2_wr = 1'b0, rd_ris = 1'b0, inta_n = 1'b1;
  logic [4:0] icw2_base = 5'h08;
  logic [7:0] ocw1_mask = '0, ocw2 = '0, ir = '0;
  logic       int_out, data_oe;
  logic [7:0] data_out, status_out;

  pic_control_logic dut (
    .clk(clk), .rst_n(rst_n), .icw_done(icw_done), .icw1_ltim(icw1_ltim),
    .icw2_base(icw2_base), .icw4_aeoi(icw4_aeoi), .ocw1_mask(ocw1_mask),
    .ocw2(ocw2), .ocw2_wr(ocw2_wr), .rd_ris(rd_ris), .ir(ir), .inta_n(inta_n),
    .int_out(int_out), .data_out(data_out), .data_oe(data_oe), .status_out(status_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_push = 0, n_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic       oe_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every new vector on the bus must match the oldest expectation
  always @(negedge clk) begin
    if (data_oe && !oe_d) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL vector: got %0h with no vector expected", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("vector", 32'(data_out), 32'(mon_e));
      end
    end
    oe_d = data_oe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input logic [7:0] v);
    exp_q.push_back(v);
    n_push++;
  endtask

  task automatic inta_seq(input logic [7:0] v);
    expect_vec(v);
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(4);
  endtask

  task automatic inta_to_ack2(input logic [7:0] v);
    expect_vec(v);
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
  endtask

  task automatic read_status(input logic ris, input logic [7:0] exp, input string name);
    rd_ris = ris;
    tick(2);
    @(negedge clk);
    check(name, 32'(status_out), 32'(exp));
    tick(1);
  endtask

  task automatic write_ocw2(input logic [7:0] v);
    ocw2 = v; ocw2_wr = 1'b1; tick(1);
    ocw2_wr = 1'b0; tick(1);
  endtask

  // model: IR0 highest; a request must rank strictly above every in-service level
  function automatic int best(input logic [7:0] pend, input logic [7:0] srv);
    for (int i = 0; i < 8; i++) begin
      if (srv[i]) return 8;
      if (pend[i]) return i;
    end
    return 8;
  endfunction

  logic [7:0] m_irr = '0, m_isr = '0, m_ir = '0, r, mk;
  int         b, op;
  logic [2:0] sl;

  initial begin
    tick(2);
    @(negedge clk);
    check("rst_int", 32'(int_out), 0);
    check("rst_oe", 32'(data_oe), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_status", 32'(status_out), 0);
    rst_n = 1'b1; icw_done = 1'b1;
    tick(4);

    // single request: 3-clock latency, vector 0x43
    ir = 8'h08;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_early", 32'(int_out), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_int", 32'(int_out), 1);
    check("lat_irr", 32'(status_out), 32'h08);
    tick(1);
    inta_seq(8'h43);
    read_status(1'b1, 8'h08, "ir3_isr");
    read_status(1'b0, 8'h00, "ir3_irr");
    ir = 8'h00;
    write_ocw2(8'h20);
    read_status(1'b1, 8'h00, "ir3_eoi");

    // two requests: level 2 first, level 5 held off until EOI
    ir = 8'h24; tick(6);
    inta_seq(8'h42);
    tick(2);
    @(negedge clk);
    check("nested_block", 32'(int_out), 0);
    tick(1);
    read_status(1'b0, 8'h20, "pend5_irr");
    write_ocw2(8'h20);
    @(negedge clk);
    check("nested_reassert", 32'(int_out), 1);
    tick(1);
    inta_seq(8'h45);
    ir = 8'h00;
    write_ocw2(8'h20);
    read_status(1'b1, 8'h00, "nested_isr");

    // masking
    ocw1_mask = 8'h04; ir = 8'h04; tick(6);
    @(negedge clk);
    check("masked", 32'(int_out), 0);
    tick(1);
    ocw1_mask = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("unmasked", 32'(int_out), 1);
    tick(1);
    inta_seq(8'h42);
    ir = 8'h00;
    write_ocw2(8'h20);

    // automatic EOI
    icw4_aeoi = 1'b1; ir = 8'h01; tick(6);
    inta_seq(8'h40);
    read_status(1'b1, 8'h00, "aeoi_isr");
    icw4_aeoi = 1'b0; ir = 8'h00; tick(4);

    // request withdrawn before acknowledge -> spurious level 7
    ir = 8'h10; tick(6);
    @(negedge clk);
    check("spur_pre_int", 32'(int_out), 1);
    tick(1);
    ir = 8'h00; tick(4);
    inta_seq(8'h47);
    read_status(1'b1, 8'h00, "spur_isr");
    read_status(1'b0, 8'h00, "spur_irr");

    // re-init while in ACK2
    ir = 8'h02; tick(6);
    inta_to_ack2(8'h41);
    @(negedge clk);
    check("ack2_oe", 32'(data_oe), 1);
    icw_done = 1'b0;
    @(posedge clk); #1;
    check("init_oe", 32'(data_oe), 0);
    check("init_status", 32'(status_out), 0);
    tick(2);
    icw_done = 1'b1; inta_n = 1'b1; tick(4);
    read_status(1'b1, 8'h00, "init_isr");
    ir = 8'h00; tick(4);
    ir = 8'h02; tick(6);
    inta_seq(8'h41);
    ir = 8'h00;
    write_ocw2(8'h20);

    // async reset while in ACK2
    ir = 8'h02; tick(6);
    inta_to_ack2(8'h41);
    @(negedge clk);
    check("ack2_oe_r", 32'(data_oe), 1);
    #2 rst_n = 1'b0; ir = 8'h00;
    #1;
    check("rst_oe_async", 32'(data_oe), 0);
    check("rst_int_async", 32'(int_out), 0);
    tick(2);
    inta_n = 1'b1; rst_n = 1'b1; tick(4);
    read_status(1'b1, 8'h00, "rst_isr");

    // randomized traffic against the set-based model
    m_irr = '0; m_isr = '0; m_ir = '0;
    for (int it = 0; it < 24; it++) begin
      r  = 8'($urandom);
      mk = 8'($urandom & $urandom);
      m_irr = m_irr | (r & ~m_ir);
      m_ir  = r;
      ir = r; ocw1_mask = mk;
      tick(5);
      @(negedge clk);
      check("rnd_int", 32'(int_out), (best(m_irr & ~mk, m_isr) < 8) ? 32'd1 : 32'd0);
      tick(1);
      m_irr = m_irr & m_ir;
      b = best(m_irr & ~mk, m_isr);
      if (b < 8) begin
        m_isr[b] = 1'b1;
        m_irr[b] = 1'b0;
        inta_seq({icw2_base, 3'(b)});
      end else begin
        inta_seq({icw2_base, 3'd7});
      end
      read_status(1'b1, m_isr, "rnd_isr");
      read_status(1'b0, m_irr, "rnd_irr");
      op = int'($urandom_range(0, 3));
      if (op == 1 || op == 2) begin
        b = best(8'h00, 8'h00);
        for (int i = 7; i >= 0; i--) if (m_isr[i]) b = i;
        if (b < 8) m_isr[b] = 1'b0;
        write_ocw2(8'h20);
      end else if (op == 3) begin
        sl = 3'($urandom_range(0, 7));
        m_isr[sl] = 1'b0;
        write_ocw2({3'b011, 2'b00, sl});
      end
    end

    tick(4);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("vector_count", 32'(n_seen), 32'(n_push));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pic_control_logic.md
Name: pic_control_logic

Overview:
- Interrupt core of the 8259A-style PIC, directly downstream of the read/write logic.
- Consumes the ICW/OCW words that block decodes, latches IR0..IR7 requests into IRR, applies the mask (IMR), resolves priority against ISR, raises int_out and runs the two-pulse 8086 INTA sequence.
- During the sequence it drives the vector byte and supplies IRR/ISR status for OCW3 reads.

Parameters:
- SYNC_STAGES, 2: flops on ir[7:0] and inta_n before use (min 2).
- SPURIOUS_LEVEL, 7: level reported when no request survives to the first INTA.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- icw_done  input  1  initialization complete; low = (re)init in progress.
- icw1_ltim  input  1  ICW1[3]: 1 = level-triggered, 0 = edge-triggered.
- icw2_base  input  5  ICW2[7:3]: vector base.
- icw4_aeoi  input  1  ICW4[1]: automatic EOI.
- ocw1_mask  input  8  IMR; bit n = 1 masks IRn.
- ocw2  input  8  OCW2 byte (R, SL, EOI, -, -, L2..L0).
- ocw2_wr  input  1  one-clk strobe: ocw2 is new.
- rd_ris  input  1  OCW3 RIS: 0 = IRR, 1 = ISR.
- ir  input  8  asynchronous interrupt request lines.
- inta_n  input  1  asynchronous interrupt acknowledge, active low.
- int_out  output  1  interrupt request to CPU.
- data_out  output  8  vector byte.
- data_oe  output  1  data_out valid / bus drive enable.
- status_out  output  8  IRR or ISR per rd_ris, registered.

Behaviour:
- Reset (rst_n low, async): IRR = 0, ISR = 0, state IDLE, int_out = 0, data_out = 0, data_oe = 0, status_out = 0, synchronizers = 0, priority rotation base = 0 (IR0 highest).
- icw_done low: same as reset except synchronizers keep running; inta_n pulses are ignored.
- IRR, edge mode: bit n sets on a synced 0->1 of ir[n]. It clears when acknowledged, or when synced ir[n] is low at ack time.
- IRR, level mode: IRR = synced ir every cycle.
- Eligible set = IRR & ~ocw1_mask. A level is eligible only if it has strictly higher priority than the highest ISR bit (fully nested mode).
- int_out is registered: high when any level is eligible and state is IDLE.
- Latency: ir sampled high at edge N gives IRR set at edge N+SYNC_STAGES and int_out high at edge N+SYNC_STAGES+1.
- FSM is driven by synced inta_n edges.
  - IDLE -> ACK1 on the first falling edge. That cycle: freeze lvl = highest eligible (SPURIOUS_LEVEL if none), set ISR[lvl] (not set if spurious), clear IRR[lvl], drop int_out. data_oe stays 0.
  - ACK1 -> ACK2 on the second falling edge. data_out = {icw2_base, lvl}, data_oe = 1.
  - ACK2 -> IDLE on the rising edge. data_oe = 0. If icw4_aeoi, clear ISR[lvl].
- OCW2 on ocw2_wr, decoded from bits [7:5]:
  - 001: non-specific EOI, clears the highest-priority ISR bit.
  - 011: specific EOI, clears ISR[ocw2[2:0]].
  - 010: no-op.
  - Other codes: see Optional Feature.
- Simultaneous EOI and first-INTA in the same cycle: both apply. Set wins on the same bit.
- status_out is updated every cycle from rd_ris.

Optional Feature:
- Macro: PIC_ROTATE_PRIORITY_EN.
- Defined:
  - 101: non-specific EOI, then rotate so the cleared level becomes lowest.
  - 111: specific EOI on L, then rotate L to lowest.
  - 110: set lowest priority = L.
  - 100 / 000: set / clear rotate-in-AEOI; when set, the AEOI clear also rotates.
- Undefined: rotation base fixed at 0. 101 acts as 001, 111 acts as 011; 110, 100 and 000 are ignored.

Decomposition:
- pic_pkg holds: FSM state enum (IDLE, ACK1, ACK2), OCW2 command-code localparams, NUM_IR = 8.
- Sub-module pic_priority_resolver: combinational. Inputs: request vector, ISR, rotation base. Outputs: highest eligible level + valid, highest ISR level + valid.

Test Plan:
- icw_done = 1, edge mode, mask 0, base 5'h08: pulse ir[3] -> int_out high after 3 clk; two INTA pulses -> data_out = 8'h43, ISR = 8'h08, IRR = 0.
- ir[5] and ir[2] raised together -> vector level 2 first. ir[5] stays pending; int_out stays low until OCW2 = 8'h20, then reasserts and acknowledges level 5.
- ocw1_mask = 8'h04 with ir[2] high -> int_out stays 0; unmask -> int_out rises next cycle.
- icw4_aeoi = 1: ack ir[0] -> ISR returns to 0 on the second INTA rising edge, with no OCW2 written.
- ir[4] dropped before the first INTA -> spurious, vector low bits = 3'b111, ISR unchanged.
- Reset and icw_done low asserted in ACK2 -> data_oe = 0, ISR = 0, state IDLE immediately.
